// File: rtl/hack_pc_sequencer.sv
// Fetch/execute sequencer for the Hack CPU: fetches from ROM, hands the instruction to the
// datapath, then drives the pc block's load/inc strobes from the Hack jump condition.
module hack_pc_sequencer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      pc_out,
    output logic [15:0]      pc_in,
    output logic             pc_load,
    output logic             pc_inc,
    output logic             rom_req,
    output logic [15:0]      rom_addr,
    input  logic             rom_valid,
    input  logic [15:0]      rom_data,
    output logic [15:0]      instr,
    output logic             instr_valid,
    input  logic             exec_done,
    input  logic             alu_zr,
    input  logic             alu_ng,
    input  logic [15:0]      a_reg,
    input  logic             halt,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StFetch  = 2'd1;
    localparam logic [1:0] StExec   = 2'd2;
    localparam logic [1:0] StUpdate = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [15:0]      pc_in_q;
    logic             pc_load_q, pc_inc_q;
    logic             rom_req_q;
    logic [15:0]      instr_q;
    logic             instr_valid_q;
    logic             halted_q;
    logic [CNT_W-1:0] retired_q;
    logic             jump;

    // pc_out is already the pc block's register, so the fetch address is a direct pass-through;
    // this lets the first FETCH after UPDATE present the freshly loaded/incremented PC.
    assign rom_addr    = pc_out;
    assign pc_in       = pc_in_q;
    assign pc_load     = pc_load_q;
    assign pc_inc      = pc_inc_q;
    assign rom_req     = rom_req_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign retired     = retired_q;

    // Applied literally even for the illegal zr=ng=1 flag combination.
    always_comb begin
        jump = 1'b0;
        if (instr_q[15]) begin
            jump = (instr_q[2] & alu_ng) | (instr_q[1] & alu_zr) |
                   (instr_q[0] & ~alu_ng & ~alu_zr);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!halt)     state_d = StFetch;
            StFetch:  if (rom_valid) state_d = StExec;
            StExec:   if (exec_done) state_d = StUpdate;
            StUpdate: state_d = halt ? StIdle : StFetch;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            pc_in_q       <= 16'h0000;
            pc_load_q     <= 1'b0;
            pc_inc_q      <= 1'b0;
            rom_req_q     <= 1'b0;
            instr_q       <= 16'h0000;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b1;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            rom_req_q     <= (state_d == StFetch);
            instr_valid_q <= (state_d == StExec);
            halted_q      <= (state_d == StIdle);
            pc_load_q     <= 1'b0;
            pc_inc_q      <= 1'b0;
            if (state_q == StFetch && rom_valid) begin
                instr_q <= rom_data;
            end
            // Strobes are registered on the edge entering UPDATE so they are high for exactly
            // the UPDATE cycle and the pc block commits on the edge that leaves it.
            if (state_q == StExec && exec_done) begin
                pc_load_q <= jump;
                pc_inc_q  <= ~jump;
                if (jump) begin
                    pc_in_q <= a_reg;
                end
            end
            if (state_q == StUpdate) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

endmodule
